// File: rtl/bcd_push_sequencer.sv
// Button front-end for the BCD counter: 2-flop sync + debounce per button, then an
// arbitration FSM that emits single-cycle Up_o/Dn_o steps with hold-to-repeat.
module bcd_push_sequencer #(
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter bit WRAP          = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Push,
  input  logic [11:0] Cnt_i,
  output logic        Up_o,
  output logic        Dn_o,
  output logic [2:0]  State_o
);

  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int DB_W    = $clog2(DB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FIRE     = 3'd1,
    S_HOLD     = 3'd2,
    S_RPT_FIRE = 3'd3,
    S_RPT      = 3'd4,
    S_WAIT_REL = 3'd5
  } state_t;

  logic [1:0]      sync_meta;
  logic [1:0]      sync_q;
  logic [1:0]      db_lvl;
  logic [DB_W-1:0] db_cnt [2];

  state_t           state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             fire;

  logic up_prs, dn_prs, latched_prs, other_prs;
  logic blk_up, blk_dn;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync_meta <= 2'b11;
      sync_q    <= 2'b11;
    end else begin
      sync_meta <= Push;
      sync_q    <= sync_meta;
    end
  end

  // Level flips only after DB_CYCLES back-to-back samples disagree with it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      db_lvl <= 2'b11;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_q[b] == db_lvl[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_W'(DB_CYCLES - 1)) begin
          db_lvl[b] <= sync_q[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign up_prs      = ~db_lvl[1];
  assign dn_prs      = ~db_lvl[0];
  assign latched_prs = dir_up_q ? up_prs : dn_prs;
  assign other_prs   = dir_up_q ? dn_prs : up_prs;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      dir_up_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    tmr_d    = '0;
    fire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (up_prs && dn_prs) begin
          state_d = S_WAIT_REL;
        end else if (up_prs || dn_prs) begin
          state_d  = S_FIRE;
          dir_up_d = up_prs;
        end
      end
      // A release seen while firing still lets the pulse out, then drops to idle.
      S_FIRE: begin
        fire    = 1'b1;
        tmr_d   = TMR_W'(1);
        state_d = latched_prs ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        tmr_d = tmr_q + 1'b1;
        if (!latched_prs)                            state_d = S_IDLE;
        else if (other_prs)                          state_d = S_WAIT_REL;
        else if (tmr_q == TMR_W'(HOLD_CYCLES - 1))   state_d = S_RPT_FIRE;
      end
      S_RPT_FIRE: begin
        fire    = 1'b1;
        tmr_d   = TMR_W'(1);
        state_d = latched_prs ? S_RPT : S_IDLE;
      end
      S_RPT: begin
        tmr_d = tmr_q + 1'b1;
        if (!latched_prs)                            state_d = S_IDLE;
        else if (other_prs)                          state_d = S_WAIT_REL;
        else if (tmr_q == TMR_W'(REPEAT_CYCLES - 1)) state_d = S_RPT_FIRE;
      end
      S_WAIT_REL: begin
        if (!up_prs && !dn_prs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturation masks only the pulse; the FSM timing is unaffected.
  assign blk_up  = !WRAP && (Cnt_i == 12'h999);
  assign blk_dn  = !WRAP && (Cnt_i == 12'h000);
  assign Up_o    = fire &&  dir_up_q && !blk_up;
  assign Dn_o    = fire && !dir_up_q && !blk_dn;
  assign State_o = state_q;

endmodule

// File: tb/tb_bcd_push_sequencer.sv
// Bench for bcd_push_sequencer: a WRAP=1 and a WRAP=0 instance share stimulus and
// are compared every cycle against a press-age model, plus literal pulse timings.
module tb_bcd_push_sequencer;

  localparam int DB   = 4;
  localparam int HOLD = 50;
  localparam int RPT  = 10;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Push;
  logic [11:0] Cnt;
  logic        up0, dn0, up1, dn1;
  logic [2:0]  st0, st1;

  always #10 Clk = ~Clk;

  bcd_push_sequencer #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .WRAP(1'b1)) u0 (
    .Clk(Clk), .Rst(Rst), .Push(Push), .Cnt_i(Cnt), .Up_o(up0), .Dn_o(dn0), .State_o(st0));

  bcd_push_sequencer #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .WRAP(1'b0)) u1 (
    .Clk(Clk), .Rst(Rst), .Push(Push), .Cnt_i(Cnt), .Up_o(up1), .Dn_o(dn1), .State_o(st1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base;
  int up0_q[$], dn0_q[$], up1_q[$], dn1_q[$];
  bit st_nz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    up0_q.delete(); dn0_q.delete(); up1_q.delete(); dn1_q.delete();
    st_nz = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Model: synced sample = Push two edges back; a button's level flips when the last
  // DB synced samples all disagree with it. Once armed, the output is a pure function
  // of cycles elapsed since the first pulse.
  logic [1:0] m_d1, m_d2, m_lvl, m_samp;
  logic [1:0] m_hist[$];
  int         m_mode;
  int         m_age;
  bit         m_dir;
  bit         m_pu, m_pd, m_lat, m_oth, m_diff;
  int         m_s;

  function automatic int m_state();
    if (m_mode == 0) return 0;
    if (m_mode == 2) return 5;
    if (m_age == 0) return 1;
    if (m_age < HOLD) return 2;
    if (((m_age - HOLD) % RPT) == 0) return 3;
    return 4;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_d1 = 2'b11; m_d2 = 2'b11; m_lvl = 2'b11;
      m_hist.delete();
      m_mode = 0; m_age = 0; m_dir = 1'b0;
    end else begin
      m_pu = !m_lvl[1];
      m_pd = !m_lvl[0];
      m_s  = m_state();
      case (m_mode)
        0: begin
          if (m_pu && m_pd) m_mode = 2;
          else if (m_pu || m_pd) begin m_mode = 1; m_age = 0; m_dir = m_pu; end
        end
        1: begin
          m_lat = m_dir ? m_pu : m_pd;
          m_oth = m_dir ? m_pd : m_pu;
          if (!m_lat) m_mode = 0;
          else if (m_oth && !(m_s == 1 || m_s == 3)) m_mode = 2;
          else m_age++;
        end
        default: if (!m_pu && !m_pd) m_mode = 0;
      endcase
      m_samp = m_d2; m_d2 = m_d1; m_d1 = Push;
      m_hist.push_back(m_samp);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      for (int b = 0; b < 2; b++) begin
        m_diff = (m_hist.size() == DB);
        foreach (m_hist[i]) if (m_hist[i][b] == m_lvl[b]) m_diff = 1'b0;
        if (m_diff) m_lvl[b] = ~m_lvl[b];
      end
    end
  end

  always @(posedge Clk) begin
    int  s;
    bit  f;
    cyc++;
    #5;
    s = m_state();
    f = (m_mode == 1) && (s == 1 || s == 3);
    chk("state0", int'(st0), s);
    chk("state1", int'(st1), s);
    chk("up0", int'(up0), int'(f && m_dir));
    chk("dn0", int'(dn0), int'(f && !m_dir));
    chk("up1", int'(up1), int'(f && m_dir && Cnt != 12'h999));
    chk("dn1", int'(dn1), int'(f && !m_dir && Cnt != 12'h000));
    chk("up_dn_excl", int'(up0 && dn0), 0);
    if (up0) up0_q.push_back(cyc);
    if (dn0) dn0_q.push_back(cyc);
    if (up1) up1_q.push_back(cyc);
    if (dn1) dn1_q.push_back(cyc);
    if (st0 != 3'd0) st_nz = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b0; Push = 2'b11; Cnt = 12'h500;
    #1;
    chk("rst_up0", int'(up0), 0);
    chk("rst_dn0", int'(dn0), 0);
    chk("rst_st0", int'(st0), 0);
    chk("rst_st1", int'(st1), 0);
    cycles(3);
    Rst = 1'b1;
    cycles(5);

    // Single short up press.
    clear_obs(); base = cyc;
    Push = 2'b01; cycles(10); Push = 2'b11; cycles(30);
    chk("single_up_cnt", up0_q.size(), 1);
    chk("single_up_lat", (up0_q.size() > 0) ? up0_q[0] - base : -1, 7);
    chk("single_dn_cnt", dn0_q.size(), 0);

    // 3-cycle glitch must not survive debounce.
    clear_obs();
    Push = 2'b10; cycles(3); Push = 2'b11; cycles(20);
    chk("glitch_dn_cnt", dn0_q.size(), 0);
    chk("glitch_state_nz", int'(st_nz), 0);

    // Hold for auto-repeat.
    clear_obs(); base = cyc;
    Push = 2'b01; cycles(75); Push = 2'b11; cycles(30);
    chk("hold_up_cnt", up0_q.size(), 4);
    chk("hold_p1", (up0_q.size() > 0) ? up0_q[0] - base : -1, 7);
    chk("hold_p2", (up0_q.size() > 1) ? up0_q[1] - base : -1, 57);
    chk("hold_p3", (up0_q.size() > 2) ? up0_q[2] - base : -1, 67);
    chk("hold_p4", (up0_q.size() > 3) ? up0_q[3] - base : -1, 77);

    // Both pressed -> wait for full release, then a clean down press.
    clear_obs();
    Push = 2'b00; cycles(10);
    chk("both_state", int'(st0), 5);
    Push = 2'b01; cycles(10);
    chk("one_left_state", int'(st0), 5);
    Push = 2'b11; cycles(15);
    chk("released_state", int'(st0), 0);
    chk("both_up_cnt", up0_q.size(), 0);
    chk("both_dn_cnt", dn0_q.size(), 0);
    clear_obs(); base = cyc;
    Push = 2'b10; cycles(10); Push = 2'b11; cycles(30);
    chk("after_wait_dn_cnt", dn0_q.size(), 1);
    chk("after_wait_dn_lat", (dn0_q.size() > 0) ? dn0_q[0] - base : -1, 7);
    chk("after_wait_up_cnt", up0_q.size(), 0);

    // Saturation at 999 / 000.
    Cnt = 12'h999; clear_obs();
    Push = 2'b01; cycles(10); Push = 2'b11; cycles(30);
    chk("sat999_up_nowrap", up1_q.size(), 0);
    chk("sat999_up_wrap", up0_q.size(), 1);
    clear_obs();
    Push = 2'b10; cycles(10); Push = 2'b11; cycles(30);
    chk("at999_dn_nowrap", dn1_q.size(), 1);
    Cnt = 12'h000; clear_obs();
    Push = 2'b10; cycles(10); Push = 2'b11; cycles(30);
    chk("sat000_dn_nowrap", dn1_q.size(), 0);
    chk("sat000_dn_wrap", dn0_q.size(), 1);

    // Reset while repeating, button still held across reset release.
    Cnt = 12'h500; clear_obs();
    Push = 2'b01; cycles(65);
    chk("pre_rst_state", int'(st0), 4);
    Rst = 1'b0;
    #1;
    chk("mid_rst_up0", int'(up0), 0);
    chk("mid_rst_st0", int'(st0), 0);
    chk("mid_rst_st1", int'(st1), 0);
    cycles(3);
    chk("rst_hold_st0", int'(st0), 0);
    clear_obs(); base = cyc;
    Rst = 1'b1;
    cycles(20); Push = 2'b11; cycles(30);
    chk("post_rst_up_cnt", up0_q.size(), 1);
    chk("post_rst_up_lat", (up0_q.size() > 0) ? up0_q[0] - base : -1, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
